// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : RV32I instruction-fetch sequencer. Owns the PC, issues one
//               word fetch at a time to instruction memory, buffers returned
//               words with their PC toward decode and flushes on redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2              // legal range 2..8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [31:0]   C_NOP   = 32'h0000_0013;

    // REQ: may issue a fetch; WAIT: one good fetch outstanding;
    // KILL: one stale fetch outstanding whose response must be discarded.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [CW-1:0] w_wr_idx;
    logic          r_req_valid;
    logic          r_dec_valid;

    // Buffer slots; slot 0 is always the head presented to decode. Empty
    // slots hold NOP / PC 0 so the head reads correctly when the buffer is empty.
    logic [31:0]   r_inst [FIFO_DEPTH];
    logic [31:0]   r_ipc  [FIFO_DEPTH];
    logic [31:0]   w_inst_nxt [FIFO_DEPTH];
    logic [31:0]   w_ipc_nxt  [FIFO_DEPTH];

    logic          w_hs;
    logic          w_pop;
    logic          w_push;
    logic          w_unused_bits;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign w_unused_bits = ^redirect_pc[1:0];

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign dec_valid      = r_dec_valid;
    assign dec_inst       = r_inst[0];
    assign dec_pc         = r_ipc[0];

    assign w_hs  = r_req_valid & imem_req_ready;
    assign w_pop = r_dec_valid & dec_ready;

    // Fetch sequencing: next state, next PC and whether a response is kept.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;

        if (w_hs) begin
            w_fetch_pc_nxt = r_pc;
        end

        case (r_state)
            ST_REQ: begin
                if (w_hs) begin
                    w_state_nxt = ST_WAIT;
                    w_pc_nxt    = r_pc + 32'd4;   // wraps FFFF_FFFC -> 0
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                    w_push      = 1'b1;
                end
            end
            ST_KILL: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        // A redirect overrides everything else that happens this cycle.
        if (redirect_valid) begin
            w_pc_nxt = {redirect_pc[31:2], 2'b00};
            w_push   = 1'b0;
            case (r_state)
                ST_REQ:           w_state_nxt = w_hs ? ST_KILL : ST_REQ;
                ST_WAIT, ST_KILL: w_state_nxt = imem_rsp_valid ? ST_REQ : ST_KILL;
                default:          w_state_nxt = ST_REQ;
            endcase
        end
    end

    // Buffer update: flush, or shift-on-pop followed by push at the tail.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_inst_nxt[i] = r_inst[i];
            w_ipc_nxt[i]  = r_ipc[i];
        end
        w_count_nxt = r_count;
        w_wr_idx    = r_count;

        if (redirect_valid) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                w_inst_nxt[i] = C_NOP;
                w_ipc_nxt[i]  = 32'd0;
            end
            w_count_nxt = '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    w_inst_nxt[i] = r_inst[i+1];
                    w_ipc_nxt[i]  = r_ipc[i+1];
                end
                w_inst_nxt[FIFO_DEPTH-1] = C_NOP;
                w_ipc_nxt[FIFO_DEPTH-1]  = 32'd0;
                w_count_nxt = r_count - CW'(1);
                w_wr_idx    = r_count - CW'(1);
            end
            // Requests are only issued with room, so a push never overflows.
            if (w_push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CW'(i) == w_wr_idx) begin
                        w_inst_nxt[i] = imem_rsp_data;
                        w_ipc_nxt[i]  = r_fetch_pc;
                    end
                end
                w_count_nxt = w_count_nxt + CW'(1);
            end
        end
    end

    // State, PC, buffer and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_req_valid <= 1'b0;
            r_dec_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_inst[i] <= C_NOP;
                r_ipc[i]  <= 32'd0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_count     <= w_count_nxt;
            r_req_valid <= (w_state_nxt == ST_REQ) && (w_count_nxt < C_DEPTH);
            r_dec_valid <= (w_count_nxt != '0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_inst[i] <= w_inst_nxt[i];
                r_ipc[i]  <= w_ipc_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire
